// File: rtl/i2s_mic_pkg.sv
// Shared types, default parameters and parameter legality check for the I2S mic receiver.
package i2s_mic_pkg;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } ch_t;

    localparam int DEF_CLK_DIV      = 32;
    localparam int DEF_SLOT_BITS    = 32;
    localparam int DEF_SAMPLE_WIDTH = 18;
    localparam int DEF_CHANNELS     = 1;

    function automatic bit params_ok(input int clk_div, input int slot_bits,
                                     input int sample_width, input int channels);
        return (clk_div >= 4) && ((clk_div % 2) == 0) &&
               (sample_width >= 1) && (slot_bits >= sample_width + 1) &&
               ((channels == 1) || (channels == 2));
    endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// SCK/WS generator and slot sequencer for the I2S receiver.
// Latency: sck_out/ws_out are registered and track div_cnt/frame_cnt of the same cycle.
// Backpressure: none; free-running from reset.
module i2s_clk_gen
    import i2s_mic_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int SLOT_BITS = DEF_SLOT_BITS,
    localparam int OFF_W    = $clog2(SLOT_BITS)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    output logic             sck_out,
    output logic             ws_out,
    output logic             cap_stb,
    output logic [OFF_W-1:0] slot_off,
    output ch_t              slot_ch
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int FRM_W = $clog2(2 * SLOT_BITS);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic [FRM_W-1:0] frame_cnt;
    logic [FRM_W-1:0] frame_nxt;

    always_comb begin
        cap_stb   = (div_cnt == DIV_W'(CLK_DIV - 1));
        div_nxt   = cap_stb ? '0 : div_cnt + DIV_W'(1);
        frame_nxt = frame_cnt;
        if (cap_stb) begin
            frame_nxt = (frame_cnt == FRM_W'(2 * SLOT_BITS - 1)) ? '0 : frame_cnt + FRM_W'(1);
        end
        // The capture at the end of an SCK period belongs to the slot position being entered,
        // which puts the MSB one SCK after the WS edge.
        slot_ch  = (frame_nxt >= FRM_W'(SLOT_BITS)) ? CH_RIGHT : CH_LEFT;
        slot_off = OFF_W'((slot_ch == CH_RIGHT) ? frame_nxt - FRM_W'(SLOT_BITS) : frame_nxt);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            div_cnt   <= '0;
            frame_cnt <= '0;
            sck_out   <= 1'b0;
            ws_out    <= 1'b0;
        end else begin
            div_cnt   <= div_nxt;
            frame_cnt <= frame_nxt;
            sck_out   <= (div_nxt >= DIV_W'(CLK_DIV / 2));
            ws_out    <= (frame_nxt >= FRM_W'(SLOT_BITS - 1)) &&
                         (frame_nxt <= FRM_W'(2 * SLOT_BITS - 2));
        end
    end

endmodule

// File: rtl/i2s_mic_rx.sv
// I2S MEMS mic receiver: drives SCK/WS and deserialises SD into signed samples (mono mix: I2S_MIC_MONO_MIX_EN).
// Latency: sample_out/valid_out one cycle after the capture of the last significant bit; mono one cycle after right.
// Backpressure: none; the consumer must accept every valid_out strobe.
module i2s_mic_rx
    import i2s_mic_pkg::*;
#(
    parameter int CLK_DIV      = DEF_CLK_DIV,
    parameter int SLOT_BITS    = DEF_SLOT_BITS,
    parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
    parameter int CHANNELS     = DEF_CHANNELS
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    data_in,
    output logic                    sck_out,
    output logic                    ws_out,
    output logic [SAMPLE_WIDTH-1:0] sample_out,
    output logic                    channel_out,
    output logic                    valid_out
`ifdef I2S_MIC_MONO_MIX_EN
    ,
    output logic [SAMPLE_WIDTH-1:0] mono_out,
    output logic                    mono_valid_out
`endif
);

    localparam int OFF_W = $clog2(SLOT_BITS);

    if (!params_ok(CLK_DIV, SLOT_BITS, SAMPLE_WIDTH, CHANNELS)) begin : g_bad_params
        $error("i2s_mic_rx: illegal parameter combination");
    end

    logic                    cap_stb;
    logic [OFF_W-1:0]        slot_off;
    ch_t                     slot_ch;
    logic                    in_window;
    logic                    last_bit;
    logic                    emit;
    logic [SAMPLE_WIDTH-1:0] shift_q;
    logic [SAMPLE_WIDTH-1:0] shift_nxt;

    i2s_clk_gen #(
        .CLK_DIV   (CLK_DIV),
        .SLOT_BITS (SLOT_BITS)
    ) u_clk_gen (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .sck_out  (sck_out),
        .ws_out   (ws_out),
        .cap_stb  (cap_stb),
        .slot_off (slot_off),
        .slot_ch  (slot_ch)
    );

    always_comb begin
        in_window = (slot_off >= OFF_W'(1)) && (slot_off <= OFF_W'(SAMPLE_WIDTH));
        last_bit  = cap_stb && (slot_off == OFF_W'(SAMPLE_WIDTH));
        emit      = last_bit && ((CHANNELS == 2) || (slot_ch == CH_LEFT));
        shift_nxt = (shift_q << 1) | SAMPLE_WIDTH'(data_in);
    end

    // Exactly SAMPLE_WIDTH shifts per slot fully refill the register, so it is never cleared per slot.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            shift_q     <= '0;
            sample_out  <= '0;
            channel_out <= 1'b0;
            valid_out   <= 1'b0;
        end else begin
            valid_out <= emit;
            if (cap_stb && in_window) begin
                shift_q <= shift_nxt;
            end
            if (emit) begin
                sample_out  <= shift_nxt;
                channel_out <= slot_ch;
            end
        end
    end

`ifdef I2S_MIC_MONO_MIX_EN
    if (CHANNELS != 2) begin : g_bad_mono
        $error("i2s_mic_rx: mono mix needs CHANNELS == 2");
    end

    logic [SAMPLE_WIDTH-1:0] left_q;
    logic signed [SAMPLE_WIDTH:0] mix_sum;

    always_comb begin
        mix_sum = $signed({left_q[SAMPLE_WIDTH-1], left_q}) +
                  $signed({sample_out[SAMPLE_WIDTH-1], sample_out});
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            left_q         <= '0;
            mono_out       <= '0;
            mono_valid_out <= 1'b0;
        end else begin
            mono_valid_out <= valid_out && (channel_out == CH_RIGHT);
            if (valid_out && (channel_out == CH_LEFT)) begin
                left_q <= sample_out;
            end
            if (valid_out && (channel_out == CH_RIGHT)) begin
                mono_out <= SAMPLE_WIDTH'(mix_sum >>> 1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_i2s_mic_rx.sv
// Bench for i2s_mic_rx: three configurations, frame-table stimulus, cycle-accurate arithmetic model.
module tb_i2s_mic_rx;

    localparam int NI = 3;
    localparam int SB = 32;
`ifdef I2S_MIC_MONO_MIX_EN
    localparam int CH_D = 2;
`else
    localparam int CH_D = 1;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [2:0]  din = '0;
    logic [2:0]  sck, ws, vld, chn;
    logic [17:0] smp0, smp1;
    logic [23:0] smp2;
`ifdef I2S_MIC_MONO_MIX_EN
    logic [17:0] mono0, mono1;
    logic [23:0] mono2;
    logic [2:0]  mvld;
`endif

    logic [31:0] lv [NI][8];
    logic [31:0] rv [NI][8];
    logic [31:0] hold_s [NI];
    logic        hold_c [NI];
    int cyc = 0;
    int base = 0;
    int epoch = 1;
    int checks = 0;
    int passes = 0;

    always #5 clk_in = ~clk_in;

    i2s_mic_rx #(.CLK_DIV(32), .SLOT_BITS(32), .SAMPLE_WIDTH(18), .CHANNELS(CH_D)) u_dut (
        .clk_in(clk_in), .rst_in(rst_in), .data_in(din[0]), .sck_out(sck[0]), .ws_out(ws[0]),
        .sample_out(smp0), .channel_out(chn[0]), .valid_out(vld[0])
`ifdef I2S_MIC_MONO_MIX_EN
        , .mono_out(mono0), .mono_valid_out(mvld[0])
`endif
    );

    i2s_mic_rx #(.CLK_DIV(32), .SLOT_BITS(32), .SAMPLE_WIDTH(18), .CHANNELS(2)) u_st (
        .clk_in(clk_in), .rst_in(rst_in), .data_in(din[1]), .sck_out(sck[1]), .ws_out(ws[1]),
        .sample_out(smp1), .channel_out(chn[1]), .valid_out(vld[1])
`ifdef I2S_MIC_MONO_MIX_EN
        , .mono_out(mono1), .mono_valid_out(mvld[1])
`endif
    );

    i2s_mic_rx #(.CLK_DIV(8), .SLOT_BITS(32), .SAMPLE_WIDTH(24), .CHANNELS(2)) u_w24 (
        .clk_in(clk_in), .rst_in(rst_in), .data_in(din[2]), .sck_out(sck[2]), .ws_out(ws[2]),
        .sample_out(smp2), .channel_out(chn[2]), .valid_out(vld[2])
`ifdef I2S_MIC_MONO_MIX_EN
        , .mono_out(mono2), .mono_valid_out(mvld[2])
`endif
    );

    function automatic int p_cd(input int i);
        return (i == 2) ? 8 : 32;
    endfunction

    function automatic int p_sw(input int i);
        return (i == 2) ? 24 : 18;
    endfunction

    function automatic int p_ch(input int i);
        return (i == 0) ? CH_D : 2;
    endfunction

    function automatic logic [31:0] act_s(input int i);
        case (i)
            0:       return {14'd0, smp0};
            1:       return {14'd0, smp1};
            default: return {8'd0, smp2};
        endcase
    endfunction

    function automatic int sx(input logic [31:0] v, input int sw);
        int s;
        s = int'(v << (32 - sw));
        return s >>> (32 - sw);
    endfunction

    function automatic logic [31:0] mix(input int i, input int idx);
        int m;
        logic [31:0] mask;
        m = (sx(lv[i][idx], p_sw(i)) + sx(rv[i][idx], p_sw(i))) >>> 1;
        mask = (32'd1 << p_sw(i)) - 32'd1;
        return 32'(m) & mask;
    endfunction

    // SD bit the mic presents during cycle c; it is sampled at the end of that SCK period
    // and belongs to the slot position that follows. Ignored bits carry a fill value.
    function automatic logic drv_bit(input int i, input int c);
        int cd, sw, frm, f, q, off, idx;
        logic [31:0] v;
        cd = p_cd(i);
        sw = p_sw(i);
        frm = 2 * SB * cd;
        f = c / frm;
        q = (c % frm) / cd + 1;
        if (q == 2 * SB) begin
            f = f + 1;
            q = 0;
        end
        idx = (base + f) % 8;
        off = q % SB;
        v = (q >= SB) ? rv[i][idx] : lv[i][idx];
        if (off >= 1 && off <= sw) return v[sw - off];
        return (idx != 0);
    endfunction

    task automatic check(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s inst%0d epoch%0d cyc=%0d got %h expected %h", name, inst, epoch, cyc, act, exp);
    endtask

    // One clock: advance the model cycle, compare every instance, then drive SD for this cycle.
    task automatic cycle();
        logic prev;
        @(negedge clk_in);
        prev = rst_in;
        if (prev) cyc = 0;
        else cyc++;
        for (int i = 0; i < NI; i++) begin
            int cd, sw, frm, t, idx, pos;
            logic ev, emv, esck, ews;
            logic [31:0] em;
            cd = p_cd(i);
            sw = p_sw(i);
            frm = 2 * SB * cd;
            t = cyc % frm;
            idx = (base + cyc / frm) % 8;
            pos = t / cd;
            ev = 1'b0;
            emv = 1'b0;
            em = '0;
            if (prev) begin
                hold_s[i] = '0;
                hold_c[i] = 1'b0;
            end else if (t == sw * cd) begin
                ev = 1'b1;
                hold_s[i] = lv[i][idx];
                hold_c[i] = 1'b0;
            end else if (p_ch(i) == 2 && t == (SB + sw) * cd) begin
                ev = 1'b1;
                hold_s[i] = rv[i][idx];
                hold_c[i] = 1'b1;
            end else if (p_ch(i) == 2 && t == (SB + sw) * cd + 1) begin
                emv = 1'b1;
                em = mix(i, idx);
            end
            esck = ((cyc % cd) >= cd / 2);
            ews = (pos >= SB - 1) && (pos <= 2 * SB - 2);
            check("outputs", i, {28'd0, sck[i], ws[i], vld[i], chn[i], act_s(i)},
                  {28'd0, esck, ews, ev, hold_c[i], hold_s[i]});
`ifdef I2S_MIC_MONO_MIX_EN
            begin
                logic [31:0] am;
                am = (i == 0) ? {14'd0, mono0} : (i == 1) ? {14'd0, mono1} : {8'd0, mono2};
                check("mono", i, {31'd0, mvld[i], (mvld[i] ? am : 32'd0)}, {31'd0, emv, em});
            end
`endif
            din[i] = drv_bit(i, cyc);
        end
    endtask

    // Hand-computed expectations that pin the model at known cycles.
    task automatic pins();
        if (epoch == 1) begin
            case (cyc)
                15:   check("sck_low_c15", 0, {63'd0, sck[0]}, 64'd0);
                16:   check("sck_high_c16", 0, {63'd0, sck[0]}, 64'd1);
                575:  check("no_valid_c575", 0, {63'd0, vld[0]}, 64'd0);
                576:  check("first_valid_c576", 0, {44'd0, vld[0], chn[0], smp0}, {44'd0, 1'b1, 1'b0, 18'h00000});
                577:  check("valid_one_cycle", 0, {63'd0, vld[0]}, 64'd0);
                704:  check("w24_first", 2, {39'd0, vld[2], smp2}, {39'd0, 1'b1, 24'h800001});
                991:  check("ws_low_c991", 0, {63'd0, ws[0]}, 64'd0);
                992:  check("ws_rise_c992", 0, {63'd0, ws[0]}, 64'd1);
                1216: check("w24_next_frame", 2, {39'd0, vld[2], smp2}, {39'd0, 1'b1, 24'h7FFFFF});
                2015: check("ws_high_c2015", 0, {63'd0, ws[0]}, 64'd1);
                2016: check("ws_fall_c2016", 0, {63'd0, ws[0]}, 64'd0);
                2624: begin
                    check("left_2aaaa", 0, {44'd0, vld[0], smp0[17], smp0}, {44'd0, 1'b1, 1'b1, 18'h2AAAA});
                    check("st_left", 1, {44'd0, vld[1], chn[1], smp1}, {44'd0, 1'b1, 1'b0, 18'h1FFFF});
                end
                3648: begin
                    check("st_right", 1, {44'd0, vld[1], chn[1], smp1}, {44'd0, 1'b1, 1'b1, 18'h20000});
`ifndef I2S_MIC_MONO_MIX_EN
                    check("mono_cfg_no_right", 0, {63'd0, vld[0]}, 64'd0);
`endif
                end
                default: ;
            endcase
        end else begin
            case (cyc)
                576: check("after_reset_01234", 0, {44'd0, vld[0], chn[0], smp0}, {44'd0, 1'b1, 1'b0, 18'h01234});
`ifdef I2S_MIC_MONO_MIX_EN
                3648: check("mono_not_yet", 1, {63'd0, mvld[1]}, 64'd0);
                3649: check("mono_zero", 1, {45'd0, mvld[1], mono1}, {45'd0, 1'b1, 18'h00000});
`endif
                default: ;
            endcase
        end
    endtask

    initial begin
        lv[0] = '{32'h00000, 32'h2AAAA, 32'h3FFFF, 32'h0ABCD, 32'h01234, 32'h15555, 32'h00010, 32'h3FFFF};
        rv[0] = '{32'h00000, 32'h1FFFF, 32'h12345, 32'h20000, 32'h3FFF0, 32'h00001, 32'h3FFF0, 32'h00000};
        lv[1] = '{32'h00000, 32'h1FFFF, 32'h00010, 32'h2AAAA, 32'h01234, 32'h00010, 32'h3FFFF, 32'h00000};
        rv[1] = '{32'h00000, 32'h20000, 32'h3FFF0, 32'h15555, 32'h20000, 32'h3FFF0, 32'h00001, 32'h00000};
        lv[2] = '{32'h000000, 32'h800001, 32'h7FFFFF, 32'h123456, 32'hFFFFFF, 32'h000001, 32'hABCDEF, 32'h800000};
        rv[2] = '{32'h000000, 32'h7FFFFF, 32'h800001, 32'h654321, 32'h000000, 32'hFFFFFF, 32'h13579B, 32'h000001};
        for (int i = 0; i < NI; i++) begin
            hold_s[i] = '0;
            hold_c[i] = 1'b0;
        end

        repeat (3) cycle();
        rst_in = 1'b0;
        // Run two full frames, then reset while bit 9 of the third left slot is being shifted in.
        while (cyc < 2 * 2048 + 9 * 32 - 18) begin
            cycle();
            pins();
        end
        rst_in = 1'b1;
        base = 4;
        repeat (5) cycle();
        epoch = 2;
        rst_in = 1'b0;
        while (cyc < 2 * 2048 + 700) begin
            cycle();
            pins();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
